// File: rtl/rs5_wb_data_bridge.sv
// RS5 native data-memory port to pipelined Wishbone master.
// Stalls the core per access; a watchdog ends transactions that never see an ack.
module rs5_wb_data_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_mem_en_i,
    input  logic [DATA_WIDTH/8-1:0] core_wen_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    core_stall_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i,
    output logic                    timeout_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [SEL_W-1:0]      r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_timeout;
    logic [CW-1:0]         r_cnt;

    state_t                w_state_nxt;
    logic                  w_cyc_nxt;
    logic                  w_stb_nxt;
    logic                  w_we_nxt;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_timeout_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_is_write;

    assign w_is_write = |core_wen_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_nxt     = r_cyc;
        w_stb_nxt     = r_stb;
        w_we_nxt      = r_we;
        w_sel_nxt     = r_sel;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rdata_nxt   = r_rdata;
        w_timeout_nxt = r_timeout;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (core_mem_en_i) begin
                    w_state_nxt = S_REQ;
                    w_cyc_nxt   = 1'b1;
                    w_stb_nxt   = 1'b1;
                    w_we_nxt    = w_is_write;
                    w_sel_nxt   = w_is_write ? core_wen_i : '1;
                    w_addr_nxt  = core_addr_i & ALIGN_MASK;
                    w_wdata_nxt = core_wdata_i;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                w_stb_nxt = 1'b0;
                if (wb_ack_i) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = 1'b0;
                    if (!r_we) w_rdata_nxt = wb_data_i;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CW'(1);
                // ack is checked first so it wins over a simultaneous timeout
                if (wb_ack_i) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = 1'b0;
                    if (!r_we) w_rdata_nxt = wb_data_i;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt   = S_DONE;
                    w_cyc_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                    if (!r_we) w_rdata_nxt = TIMEOUT_DATA;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_stb     <= w_stb_nxt;
            r_we      <= w_we_nxt;
            r_sel     <= w_sel_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rdata   <= w_rdata_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign core_stall_o = (r_state == S_REQ) || (r_state == S_WAIT) ||
                          ((r_state == S_IDLE) && core_mem_en_i);

    assign core_rdata_o = r_rdata;
    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_we;
    assign wb_sel_o     = r_sel;
    assign wb_addr_o    = r_addr;
    assign wb_data_o    = r_wdata;
    assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_rs5_wb_data_bridge.sv
// Scoreboard bench for rs5_wb_data_bridge: stimulus pushes expected
// transactions, a negedge monitor pops and compares at each DONE cycle.
module tb_rs5_wb_data_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_mem_en_i = 1'b0;
    logic [3:0]  core_wen_i = 4'h0;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wdata_i = 32'h0;
    logic [31:0] core_rdata_o;
    logic        core_stall_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        timeout_o;

    rs5_wb_data_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .core_mem_en_i(core_mem_en_i),
        .core_wen_i(core_wen_i),
        .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i),
        .core_rdata_o(core_rdata_o),
        .core_stall_o(core_stall_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o),
        .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        to;
        logic [7:0]  stall;
    } exp_t;

    exp_t        q[$];
    int          chk_n = 0;
    int          err_n = 0;
    logic [31:0] mdl_rd = 32'h0;
    logic        mdl_to = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // n = WAIT cycles before ack (0 = ack in REQ); ack_en=0 never acks
    task automatic txn(input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input int n,
                       input bit ack_en, input logic [31:0] rdata,
                       input bit hold);
        exp_t e;
        bit   rd;
        rd      = (wen == 4'h0);
        e.we    = !rd;
        e.sel   = rd ? 4'hF : wen;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.data  = wdata;
        if (rd) mdl_rd = ack_en ? rdata : 32'hDEADBEEF;
        if (!ack_en) mdl_to = 1'b1;
        e.rdata = mdl_rd;
        e.to    = mdl_to;
        e.stall = 8'(2 + n);
        q.push_back(e);
        core_mem_en_i = 1'b1;
        core_wen_i    = wen;
        core_addr_i   = addr;
        core_wdata_i  = wdata;
        wb_ack_i      = 1'b0;
        wb_data_i     = 32'h0;
        @(posedge clk); #1;
        if (!hold) begin
            core_mem_en_i = 1'b0;
            core_wen_i    = ~wen;
            core_addr_i   = ~addr;
            core_wdata_i  = ~wdata;
        end
        repeat (n) begin
            @(posedge clk); #1;
        end
        if (ack_en) begin
            wb_ack_i  = 1'b1;
            wb_data_i = rdata;
        end
        @(posedge clk); #1;
        wb_ack_i  = 1'b0;
        wb_data_i = 32'h5A5A_5A5A;
        @(posedge clk); #1;
    endtask

    int          m_stall = 0;
    int          m_stb = 0;
    int          m_cyc = 0;
    bit          m_prev = 1'b0;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev  = 1'b0;
            m_stall = 0;
            m_stb   = 0;
            m_cyc   = 0;
        end else begin
            if (wb_stb_o) begin
                m_stb++;
                m_we   = wb_we_o;
                m_sel  = wb_sel_o;
                m_addr = wb_addr_o;
                m_data = wb_data_o;
            end
            if (wb_cyc_o) m_cyc++;
            if (core_stall_o) begin
                m_stall++;
            end else if (m_prev) begin
                if (q.size() == 0) begin
                    chk_n++;
                    err_n++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    m_e = q.pop_front();
                    check("we", 32'(m_we), 32'(m_e.we));
                    check("sel", 32'(m_sel), 32'(m_e.sel));
                    check("addr", m_addr, m_e.addr);
                    check("wdata", m_data, m_e.data);
                    check("rdata", core_rdata_o, m_e.rdata);
                    check("timeout", 32'(timeout_o), 32'(m_e.to));
                    check("stall_cycles", 32'(m_stall), 32'(m_e.stall));
                    check("cyc_cycles", 32'(m_cyc), 32'(m_e.stall) - 32'd1);
                    check("stb_pulses", 32'(m_stb), 32'd1);
                    check("cyc_at_done", 32'(wb_cyc_o), 32'd0);
                end
                m_stall = 0;
                m_stb   = 0;
                m_cyc   = 0;
            end
            m_prev = core_stall_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_sel", 32'(wb_sel_o), 32'd0);
        check("rst_addr", wb_addr_o, 32'd0);
        check("rst_data", wb_data_o, 32'd0);
        check("rst_rdata", core_rdata_o, 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_stall", 32'(core_stall_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn(4'h0, 32'h0000_1006, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0);
        txn(4'b0100, 32'h0000_2002, 32'h00AB_0000, 5, 1'b1, 32'hFFFF_FFFF, 1'b0);
        txn(4'h0, 32'h0000_3000, 32'h0, 3, 1'b1, 32'hA5A5_0F0F, 1'b0);
        txn(4'h0, 32'h0000_4008, 32'h0, 8, 1'b1, 32'h0BAD_F00D, 1'b0);
        check("no_timeout_yet", 32'(timeout_o), 32'd0);
        txn(4'h0, 32'h0000_500C, 32'h0, 8, 1'b0, 32'h0, 1'b0);
        check("timeout_set", 32'(timeout_o), 32'd1);
        txn(4'hF, 32'h0000_6001, 32'hCAFE_0001, 8, 1'b0, 32'h0, 1'b0);
        txn(4'h0, 32'h0000_6010, 32'h0, 1, 1'b1, 32'h1111_2222, 1'b0);
        txn(4'h0, 32'h0000_7004, 32'h0, 0, 1'b1, 32'h3333_4444, 1'b1);
        txn(4'b0011, 32'h0000_7007, 32'h5555_AAAA, 0, 1'b1, 32'h7777_8888, 1'b0);
        check("timeout_sticky", 32'(timeout_o), 32'd1);
        check("queue_drained_pre_rst", 32'(q.size()), 32'd0);

        core_mem_en_i = 1'b1;
        core_wen_i    = 4'h0;
        core_addr_i   = 32'h0000_8000;
        @(posedge clk); #1;
        core_mem_en_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midwait_cyc", 32'(wb_cyc_o), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("postrst_cyc", 32'(wb_cyc_o), 32'd0);
        check("postrst_stb", 32'(wb_stb_o), 32'd0);
        check("postrst_stall", 32'(core_stall_o), 32'd0);
        check("postrst_timeout", 32'(timeout_o), 32'd0);
        check("postrst_rdata", core_rdata_o, 32'd0);
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        check("lateack_rdata", core_rdata_o, 32'd0);
        check("lateack_cyc", 32'(wb_cyc_o), 32'd0);
        check("lateack_stall", 32'(core_stall_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("lateack_rdata_hold", core_rdata_o, 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end

endmodule

// File: doc/rs5_wb_data_bridge.md
Name: rs5_wb_data_bridge

Overview:
Converts the RS5 core's native data-memory port into a pipelined Wishbone master. It drives the data_mem_* bus that feeds the registered-ack path in processorci_top. The block stalls the core for the full duration of each transaction and returns read data to it. A watchdog terminates any transaction that receives no ack, so a missing slave cannot hang the core.

Parameters:
ADDR_WIDTH, 32, width of core address and Wishbone address
DATA_WIDTH, 32, width of data paths; sel width is DATA_WIDTH/8
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before forced termination; must be >= 2
TIMEOUT_DATA, 32'hDEADBEEF, read data returned to the core on timeout

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  synchronous, active-low reset
core_mem_en_i  input  1  core data request (RS5 mem_operation_enable_o)
core_wen_i  input  4  core byte write enables (RS5 mem_write_enable_o); all zero = read
core_addr_i  input  ADDR_WIDTH  core byte address
core_wdata_i  input  DATA_WIDTH  core write data
core_rdata_o  output  DATA_WIDTH  read data to the core (RS5 mem_data_i)
core_stall_o  output  1  stall to the core
wb_cyc_o  output  1  Wishbone cycle
wb_stb_o  output  1  Wishbone strobe, pipelined mode
wb_we_o  output  1  Wishbone write
wb_sel_o  output  4  Wishbone byte selects
wb_addr_o  output  ADDR_WIDTH  Wishbone address, word aligned
wb_data_o  output  DATA_WIDTH  Wishbone write data
wb_data_i  input  DATA_WIDTH  Wishbone read data
wb_ack_i  input  1  Wishbone acknowledge
timeout_o  output  1  sticky flag: at least one transaction timed out

Behaviour:
Reset: while rst_n is low at a clk edge, state returns to IDLE.
- All wb_* outputs, core_rdata_o, timeout_o and the timeout counter are cleared.
- Reset has priority over every other event, including mid-transaction.
- Any ack arriving after reset is ignored.

States:
- IDLE:
  - On core_mem_en_i=1, latch the request and go to REQ.
  - Outputs registered on that edge: wb_cyc_o=1, wb_stb_o=1, wb_we_o=|core_wen_i.
  - wb_sel_o = core_wen_i when writing, 4'hF when reading.
  - wb_addr_o = core_addr_i with bits [1:0] forced to 0; wb_data_o = core_wdata_i.
  - wb_ack_i is ignored in IDLE.
- REQ:
  - Lasts exactly one cycle, with stb high; wb_stb_o clears on exit.
  - If wb_ack_i=1 in this cycle, go to DONE; otherwise go to WAIT.
- WAIT:
  - wb_cyc_o stays 1 and wb_stb_o stays 0.
  - The timeout counter increments every cycle.
  - On wb_ack_i=1: go to DONE, capture wb_data_i into core_rdata_o (reads only), and clear wb_cyc_o.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE, set core_rdata_o=TIMEOUT_DATA (reads only), set timeout_o=1, and clear wb_cyc_o.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - Lasts one cycle, with core_stall_o=0.
  - core_rdata_o holds valid data; the core samples it and advances.
  - core_mem_en_i is ignored, because it still reflects the old request.
  - Always go to IDLE and clear the counter.

Outputs and timing:
- core_stall_o is combinational: 1 in REQ and WAIT, 1 in IDLE when core_mem_en_i=1, otherwise 0.
- core_rdata_o holds its last value except at the capture points above; it is not updated on writes.
- Minimum latency, with ack in the REQ cycle: request seen in IDLE in cycle 0, REQ in cycle 1, DONE in cycle 2 with data valid and stall low. Three stalled-or-done cycles per access.
- Back-to-back requests: the next request is accepted in the IDLE cycle that follows DONE.
- Because the request is latched in IDLE, core inputs need not stay stable while stalled.
- timeout_o clears only on reset.
- Exactly one stb pulse per transaction; cyc stays high from REQ until the cycle of ack or timeout.

Test Plan:
- Read, ack in REQ: core_mem_en_i=1, wen=0, addr=0x0000_1006, wb_data_i=0x1234_5678, ack in cycle 1 -> wb_addr_o=0x0000_1004, sel=4'hF, we=0; stall high in cycles 0-1; cycle 2 stall=0, core_rdata_o=0x1234_5678; IDLE in cycle 3.
- Byte write, ack after 5 wait cycles: wen=4'b0100, addr=0x2002, wdata=0x00AB_0000 -> we=1, sel=4'b0100, one stb pulse; cyc high until ack; core_rdata_o unchanged; stall low only in the DONE cycle.
- Timeout with TIMEOUT_CYCLES=8 and no ack on a read -> cyc drops after 8 WAIT cycles; core_rdata_o=0xDEADBEEF; timeout_o=1 and stays 1 through the next successful access.
- Ack and timeout in the same cycle -> wb_data_i is returned and timeout_o stays 0.
- Back-to-back: a read then a write with core_mem_en_i held high throughout -> two distinct stb pulses; the DONE cycle issues no extra request; the second transaction is latched in the following IDLE.
- Reset mid-WAIT: rst_n=0 for one edge while cyc=1 -> cyc, stb and stall return to 0; a late ack one cycle after reset has no effect and core_rdata_o=0.
